// File: rtl/tx_lane_arbiter.sv
// Two-lane TX byte arbiter: per-lane FIFOs merged round-robin into one
// registered byte stream, with a COM preamble after every enable rise.
module tx_lane_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SYNC_LEN   = 4,
  parameter logic [7:0]  COM        = 8'hBC,
  parameter logic [7:0]  IDL        = 8'h7C
) (
  input  logic       clk_2f,
  input  logic       reset_L,
  input  logic       enable,
  input  logic       valid_data_0,
  input  logic [7:0] data_in_0,
  input  logic       valid_data_1,
  input  logic [7:0] data_in_1,
  output logic       full_0,
  output logic       full_1,
  output logic       overflow_0,
  output logic       overflow_1,
  output logic       valid_out,
  output logic       lane_out,
  output logic [7:0] data_out
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SYNC_W = $clog2(SYNC_LEN + 1);
  localparam int unsigned NLANE  = 2;

  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;

  state_t             state, state_nxt;
  logic [SYNC_W-1:0]  sync_cnt, sync_nxt;
  logic               last_grant, last_nxt;
  logic [7:0]         data_nxt;
  logic               valid_nxt;
  logic               lane_nxt;

  logic [7:0]         mem     [NLANE][FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr  [NLANE];
  logic [PTR_W-1:0]   rd_ptr  [NLANE];
  logic [CNT_W-1:0]   count   [NLANE];
  logic [CNT_W-1:0]   count_nxt_c [NLANE];
  logic               full_q  [NLANE];
  logic               ovf_q   [NLANE];

  logic               wr_req_c [NLANE];
  logic [7:0]         din_c    [NLANE];
  logic               wr_en_c  [NLANE];
  logic               pop_c    [NLANE];
  logic               nempty_c [NLANE];

  assign wr_req_c[0] = valid_data_0;
  assign wr_req_c[1] = valid_data_1;
  assign din_c[0]    = data_in_0;
  assign din_c[1]    = data_in_1;

  assign full_0     = full_q[0];
  assign full_1     = full_q[1];
  assign overflow_0 = ovf_q[0];
  assign overflow_1 = ovf_q[1];

  // Write qualification against the pre-edge full flag, and next occupancy
  always_comb begin
    for (int i = 0; i < NLANE; i++) begin
      wr_en_c[i]     = wr_req_c[i] & ~full_q[i];
      nempty_c[i]    = (count[i] != '0);
      count_nxt_c[i] = count[i] + CNT_W'(wr_en_c[i]) - CNT_W'(pop_c[i]);
    end
  end

  // FIFO storage; contents need no reset, pointers/count define validity
  always_ff @(posedge clk_2f) begin
    for (int i = 0; i < NLANE; i++) begin
      if (wr_en_c[i]) mem[i][wr_ptr[i]] <= din_c[i];
    end
  end

  // FIFO pointers, occupancy, full and sticky overflow flags
  always_ff @(posedge clk_2f) begin
    for (int i = 0; i < NLANE; i++) begin
      if (!reset_L) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
        full_q[i] <= 1'b0;
        ovf_q[i]  <= 1'b0;
      end else begin
        if (wr_en_c[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop_c[i])   rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        count[i]  <= count_nxt_c[i];
        full_q[i] <= (count_nxt_c[i] == CNT_W'(FIFO_DEPTH));
        if (wr_req_c[i] && full_q[i]) ovf_q[i] <= 1'b1;
      end
    end
  end

  // Scheduler state register and registered output stream
  always_ff @(posedge clk_2f) begin
    if (!reset_L) begin
      state      <= IDLE;
      sync_cnt   <= '0;
      last_grant <= 1'b1;
      data_out   <= IDL;
      valid_out  <= 1'b0;
      lane_out   <= 1'b0;
    end else begin
      state      <= state_nxt;
      sync_cnt   <= sync_nxt;
      last_grant <= last_nxt;
      data_out   <= data_nxt;
      valid_out  <= valid_nxt;
      lane_out   <= lane_nxt;
    end
  end

  // Next-state, preamble counting and round-robin grant
  always_comb begin
    state_nxt = state;
    sync_nxt  = sync_cnt;
    last_nxt  = last_grant;
    data_nxt  = IDL;
    valid_nxt = 1'b0;
    lane_nxt  = lane_out;
    pop_c[0]  = 1'b0;
    pop_c[1]  = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = SYNC;
          sync_nxt  = '0;
        end
      end
      SYNC: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else begin
          data_nxt = COM;
          sync_nxt = sync_cnt + SYNC_W'(1);
          if (sync_cnt == SYNC_W'(SYNC_LEN - 1)) state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (nempty_c[0] || nempty_c[1]) begin
          // Prefer the lane not served last when both have data
          if (nempty_c[0] && nempty_c[1]) lane_nxt = ~last_grant;
          else                            lane_nxt = nempty_c[1];
          pop_c[lane_nxt] = 1'b1;
          data_nxt        = mem[lane_nxt][rd_ptr[lane_nxt]];
          valid_nxt       = 1'b1;
          last_nxt        = lane_nxt;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
